// File: rtl/poly_synth_core_if.sv
// Keypad/audio bundle between the keypad front end and poly_synth_core.
// SYNTH_OCTAVE_SHIFT_EN adds the octave_i select.
interface poly_synth_core_if #(
  parameter int KEYS   = 15,
  parameter int VOICES = 4
);
  logic              en;
  logic [KEYS-1:0]   keypad_i;
  logic              pwm_o;
  logic [VOICES-1:0] active_o;
`ifdef SYNTH_OCTAVE_SHIFT_EN
  logic [1:0]        octave_i;
`endif

  modport master (
    output en, keypad_i,
`ifdef SYNTH_OCTAVE_SHIFT_EN
    output octave_i,
`endif
    input  pwm_o, active_o
  );

  modport slave (
    input  en, keypad_i,
`ifdef SYNTH_OCTAVE_SHIFT_EN
    input  octave_i,
`endif
    output pwm_o, active_o
  );
endinterface

// File: rtl/poly_synth_core.sv
// Polyphonic keypad synth: press-edge voice allocation, square-wave voices with decay, PWM mix.
// Optional SYNTH_OCTAVE_SHIFT_EN: voices latch HALF[k] >> octave_i at allocation/retrigger.
module poly_synth_voice #(
  parameter int KW          = 4,
  parameter int AMP_W       = 4,
  parameter int HW          = 15,
  parameter int DECAY_TICKS = 256
)(
  input  logic                clk,
  input  logic                n_rst,
  input  logic                en,
  input  logic                tick,
  input  logic                alloc,
  input  logic                retrig,
  input  logic [(1<<KW)-1:0]  keys,
  input  logic [KW-1:0]       new_key,
  input  logic [HW-1:0]       new_half,
  output logic                idle,
  output logic                rel,
  output logic [KW-1:0]       owner,
  output logic [AMP_W-1:0]    amp,
  output logic                sq
);
  localparam int DW = $clog2(DECAY_TICKS) + 1;
  localparam logic [AMP_W-1:0] FULL = '1;

  typedef enum logic [1:0] {IDLE, HOLD, RELEASE} vstate_t;

  vstate_t       st;
  logic [HW-1:0] half, div;
  logic [DW-1:0] dcnt;

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      st <= IDLE; amp <= '0; owner <= '0; half <= '0; div <= '0; sq <= 1'b0; dcnt <= '0;
    end else if (!en) begin
      st <= IDLE; amp <= '0;
    end else begin
      // Retrigger leaves the divider running so the waveform phase is continuous.
      if (alloc) begin
        div <= new_half; sq <= 1'b1; owner <= new_key;
      end else if (st != IDLE && tick) begin
        if (div <= HW'(1)) begin
          div <= half; sq <= ~sq;
        end else begin
          div <= div - 1'b1;
        end
      end
      if (alloc || retrig) begin
        st <= HOLD; amp <= FULL; half <= new_half; dcnt <= '0;
      end else begin
        case (st)
          HOLD: if (!keys[owner]) begin
            st <= RELEASE; dcnt <= '0;
          end
          RELEASE: if (amp == '0) begin
            st <= IDLE;
          end else if (tick) begin
            if (dcnt == DW'(DECAY_TICKS - 1)) begin
              dcnt <= '0;
              amp  <= amp - 1'b1;
              if (amp == AMP_W'(1)) st <= IDLE;
            end else begin
              dcnt <= dcnt + 1'b1;
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign idle = (st == IDLE);
  assign rel  = (st == RELEASE);
endmodule

module poly_synth_core #(
  parameter int KEYS        = 15,
  parameter int VOICES      = 4,
  parameter int AMP_W       = 4,
  parameter int PRESCALE    = 1,
  parameter int DECAY_TICKS = 256
)(
  input  logic               clk,
  input  logic               n_rst,
  poly_synth_core_if.slave   bus
);
  localparam int KW    = (KEYS > 1) ? $clog2(KEYS) : 1;
  localparam int KP    = 1 << KW;
  localparam int HW    = 15;
  localparam int MIX_W = AMP_W + $clog2(VOICES) + 1;
  localparam int PW    = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

  // Half-period in 10 MHz ticks; octaves above the table are rounded halvings (key 13 exact).
  function automatic int half_of(input int k);
    int b;
    case (k % 12)
      0: b = 19111;  1: b = 18039;  2: b = 17026;  3: b = 16071;
      4: b = 15169;  5: b = 14317;  6: b = 13514;  7: b = 12755;
      8: b = 12039;  9: b = 11364; 10: b = 10726; default: b = 10124;
    endcase
    if (k == 13) return 9019;
    return (b + ((1 << (k / 12)) >> 1)) >> (k / 12);
  endfunction

  logic [KEYS-1:0]              key_q, pending, cand;
  logic [KP-1:0]                keys;
  logic [KP-1:0][HW-1:0]        half_tab;
  logic                         serve, hit;
  logic [KW-1:0]                sel;
  logic [HW-1:0]                sel_half;
  logic [VOICES-1:0]            alloc, retrig, v_idle, v_rel, v_sq;
  logic [VOICES-1:0][KW-1:0]    v_owner;
  logic [VOICES-1:0][AMP_W-1:0] v_amp;
  logic [PW-1:0]                pre_cnt;
  logic                         tick;
  logic [MIX_W-1:0]             mix, mix_sum, pwm_cnt;

  assign keys = KP'(bus.keypad_i);
  assign cand = pending & bus.keypad_i;

  for (genvar g = 0; g < KP; g++) begin : g_half
    assign half_tab[g] = HW'(half_of(g < KEYS ? g : 0));
  end

`ifdef SYNTH_OCTAVE_SHIFT_EN
  assign sel_half = half_tab[sel] >> bus.octave_i;
`else
  assign sel_half = half_tab[sel];
`endif

  always_comb begin
    serve = 1'b0;
    sel   = '0;
    for (int k = KEYS - 1; k >= 0; k--)
      if (cand[k]) begin serve = 1'b1; sel = KW'(k); end
  end

  // A releasing owner of the key wins over a fresh idle voice; no stealing otherwise.
  always_comb begin
    hit    = 1'b0;
    retrig = '0;
    alloc  = '0;
    for (int v = VOICES - 1; v >= 0; v--)
      if (serve && v_rel[v] && v_owner[v] == sel) begin
        retrig = '0; retrig[v] = 1'b1; hit = 1'b1;
      end
    for (int v = VOICES - 1; v >= 0; v--)
      if (serve && !hit && v_idle[v]) begin
        alloc = '0; alloc[v] = 1'b1;
      end
  end

  assign tick = (pre_cnt == PW'(PRESCALE - 1));

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      key_q <= '0; pending <= '0; pre_cnt <= '0;
    end else begin
      key_q   <= bus.keypad_i;
      pre_cnt <= tick ? '0 : pre_cnt + 1'b1;
      if (!bus.en) begin
        pending <= '0;
      end else begin
        pending <= (pending | (bus.keypad_i & ~key_q)) & bus.keypad_i;
        if (serve) pending[sel] <= 1'b0;
      end
    end
  end

  for (genvar v = 0; v < VOICES; v++) begin : g_voice
    poly_synth_voice #(
      .KW(KW), .AMP_W(AMP_W), .HW(HW), .DECAY_TICKS(DECAY_TICKS)
    ) u_voice (
      .clk(clk), .n_rst(n_rst), .en(bus.en), .tick(tick),
      .alloc(alloc[v]), .retrig(retrig[v]), .keys(keys),
      .new_key(sel), .new_half(sel_half),
      .idle(v_idle[v]), .rel(v_rel[v]), .owner(v_owner[v]),
      .amp(v_amp[v]), .sq(v_sq[v])
    );
  end

  always_comb begin
    mix_sum = '0;
    for (int v = 0; v < VOICES; v++)
      if (v_sq[v]) mix_sum = mix_sum + MIX_W'(v_amp[v]);
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      mix <= '0; pwm_cnt <= '0; bus.pwm_o <= 1'b0;
    end else begin
      mix       <= bus.en ? mix_sum : '0;
      pwm_cnt   <= pwm_cnt + 1'b1;
      bus.pwm_o <= (pwm_cnt < mix);
    end
  end

  assign bus.active_o = ~v_idle;
endmodule
